// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encodings for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } divState_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-compare-subtract iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift the next dividend bit into the partial remainder; keep the difference only if non-negative
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            remOut = diff[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = shifted[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div.sv
// rtl/div.sv - multi-cycle signed/unsigned divider with pipeline stall handshake
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_div,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_div
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    divState_t state, nextState;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic             signedReg;
    logic             aSign;
    logic             bSign;
    logic             accept;

    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic [WIDTH-1:0] remFix;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Operand magnitudes are only taken for signed division
    always_comb begin
        aMag = (signed_div && a[WIDTH-1]) ? -a : a;
        bMag = (signed_div && b[WIDTH-1]) ? -b : b;
    end

    // Sign fixup of the final step: quotient follows sign mismatch, remainder follows dividend
    always_comb begin
        quoFix = (signedReg && (aSign ^ bSign)) ? -stepQuo : stepQuo;
        remFix = (signedReg && aSign) ? -stepRem : stepRem;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, stall request and ready; annul overrides everything
    always_comb begin
        nextState = state;
        stall_div = 1'b0;
        ready     = 1'b0;
        accept    = 1'b0;
        case (state)
            FREE: begin
                if (start && !annul) begin
                    accept    = 1'b1;
                    stall_div = 1'b1;
                    nextState = (b == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                stall_div = 1'b1;
                nextState = END;
            end
            ON: begin
                stall_div = 1'b1;
                if (count == LAST) begin
                    nextState = END;
                end
            end
            END: begin
                ready     = 1'b1;
                nextState = FREE;
            end
            default: nextState = FREE;
        endcase
        if (annul) begin
            nextState = FREE;
            stall_div = 1'b0;
            ready     = 1'b0;
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            aReg       <= '0;
            divisorReg <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            signedReg  <= 1'b0;
            aSign      <= 1'b0;
            bSign      <= 1'b0;
            result     <= '0;
        end else if (accept) begin
            count      <= '0;
            aReg       <= a;
            divisorReg <= bMag;
            remReg     <= '0;
            quoReg     <= aMag;
            signedReg  <= signed_div;
            aSign      <= a[WIDTH-1];
            bSign      <= b[WIDTH-1];
        end else if (!annul) begin
            if (state == ON) begin
                remReg <= stepRem;
                quoReg <= stepQuo;
                count  <= count + CW'(1);
                if (count == LAST) begin
                    result <= {remFix, quoFix};
                end
            end else if (state == BYZERO) begin
                result <= {aReg, {WIDTH{1'b1}}};
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for div
module tb_div;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    int checks;
    int errors;

    div #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .signed_div (signed_div),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the start of a cycle (#1 after posedge); returns at the start of the cycle after END
    task automatic runDiv(input logic [31:0] ia, input logic [31:0] ib, input logic sd,
                          input int expLat, input logic [63:0] expRes, input string tag);
        int  cyc;
        bit  got;
        a          = ia;
        b          = ib;
        signed_div = sd;
        start      = 1'b1;
        cyc        = 0;
        got        = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
            end else begin
                chk({tag, " stall"}, 64'(stall_div), 64'd1);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk({tag, " ready seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, " latency"}, 64'(cyc), 64'(expLat));
            chk({tag, " result"}, result, expRes);
            chk({tag, " stall in END"}, 64'(stall_div), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        a          = '0;
        b          = '0;
        signed_div = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;

        @(negedge clk);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset stall", 64'(stall_div), 64'd0);
        chk("reset result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        runDiv(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, "u100/7");
        start = 1'b0;
        @(negedge clk);
        chk("ready one cycle", 64'(ready), 64'd0);
        chk("result held", result, {32'd2, 32'd14});
        @(posedge clk);
        #1;

        runDiv(32'hFFFFFFF9, 32'd2, 1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s-7/2");
        runDiv(32'hFFFFFFF9, 32'd2, 1'b0, 33, {32'd1, 32'h7FFFFFFC}, "u0xFFFFFFF9/2");
        runDiv(32'h80000000, 32'hFFFFFFFF, 1'b1, 33, {32'd0, 32'h80000000}, "s overflow");
        runDiv(32'd7, 32'hFFFFFFFE, 1'b1, 33, {32'd1, 32'hFFFFFFFD}, "s7/-2");
        runDiv(32'hFFFFFFF8, 32'hFFFFFFFD, 1'b1, 33, {32'hFFFFFFFE, 32'd2}, "s-8/-3");
        runDiv(32'd5, 32'd0, 1'b0, 2, {32'd5, 32'hFFFFFFFF}, "u5/0");
        runDiv(32'hFFFFFFFB, 32'd0, 1'b1, 2, {32'hFFFFFFFB, 32'hFFFFFFFF}, "s-5/0");
        start = 1'b0;
        @(posedge clk);
        #1;

        // annul at cycle 10
        a          = 32'd50;
        b          = 32'd6;
        signed_div = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("annul stall", 64'(stall_div), 64'd0);
        chk("annul ready", 64'(ready), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        @(negedge clk);
        chk("after annul stall", 64'(stall_div), 64'd0);
        chk("after annul ready", 64'(ready), 64'd0);
        chk("after annul result", result, {32'hFFFFFFFB, 32'hFFFFFFFF});
        @(posedge clk);
        #1;
        runDiv(32'd1000, 32'd3, 1'b0, 33, {32'd1, 32'd333}, "post-annul 1000/3");
        start = 1'b0;
        @(posedge clk);
        #1;

        // reset at cycle 15
        a          = 32'd77;
        b          = 32'd5;
        signed_div = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("pre-reset ready", 64'(ready), 64'd0);
            @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("mid reset stall", 64'(stall_div), 64'd0);
        chk("mid reset ready", 64'(ready), 64'd0);
        chk("mid reset result", result, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post reset ready", 64'(ready), 64'd0);
            chk("post reset stall", 64'(stall_div), 64'd0);
            @(posedge clk);
            #1;
        end

        // back-to-back with no gap
        runDiv(32'd1234, 32'd10, 1'b0, 33, {32'd4, 32'd123}, "b2b first");
        runDiv(32'hFFFFFF9C, 32'd7, 1'b1, 33, {32'hFFFFFFFE, 32'hFFFFFFF2}, "b2b second");
        start = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
